// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for the multiply/divide unit
// and the decoder that issues to it.
package muldiv_unit_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return op <= OP_DIVU;
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide on {acc, q}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + (q[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shifted  = {acc, q[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    acc_next = sum[WIDTH:1];
    q_next   = {sum[0], q[WIDTH-1:1]};
    if (div_mode) begin
      // Remainder stays below the divisor, so diff[WIDTH] is a clean borrow flag.
      if (diff[WIDTH]) begin
        acc_next = shifted[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = diff[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Define MUL_DIV_SIGNED_EN to make MULT/DIV
// two's-complement signed; otherwise they behave as MULTU/DIVU.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] acc_reg, q_reg, opnd_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             div_reg, done_reg;
  logic [WIDTH-1:0] acc_next, q_next;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic             accept, div_zero;

  assign accept   = start && (state_reg == ST_IDLE);
  assign div_zero = is_div(op) && (b == '0);

`ifdef MUL_DIV_SIGNED_EN
  logic             a_neg, b_neg;
  logic             neg_lo_reg, neg_hi_reg;
  logic [2*WIDTH-1:0] prod_neg;

  assign a_neg    = is_signed_op(op) && a[WIDTH-1];
  assign b_neg    = is_signed_op(op) && b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign prod_neg = -{acc_reg, q_reg};

  // neg_lo covers both the product and the quotient; neg_hi is the remainder sign.
  always_comb begin
    fix_hi = acc_reg;
    fix_lo = q_reg;
    if (div_reg) begin
      if (neg_hi_reg) fix_hi = -acc_reg;
      if (neg_lo_reg) fix_lo = -q_reg;
    end else if (neg_lo_reg) begin
      fix_hi = prod_neg[2*WIDTH-1:WIDTH];
      fix_lo = prod_neg[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
    end else if (accept && is_arith(op)) begin
      neg_lo_reg <= !div_zero && (a_neg ^ b_neg);
      neg_hi_reg <= !div_zero && a_neg;
    end
  end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign fix_hi = acc_reg;
  assign fix_lo = q_reg;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (div_reg),
    .acc      (acc_reg),
    .q        (q_reg),
    .opnd     (opnd_reg),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept && is_arith(op)) state_next = div_zero ? ST_FIX : ST_ITER;
      ST_ITER: if (cnt_reg == CNT_W'(WIDTH-1)) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg  <= '0;
      acc_reg  <= '0;
      q_reg    <= '0;
      opnd_reg <= '0;
      div_reg  <= 1'b0;
      done_reg <= 1'b0;
      hi_reg   <= '0;
      lo_reg   <= '0;
    end else begin
      done_reg <= (state_reg == ST_FIX);
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_MTHI) begin
              hi_reg <= a;
            end else if (op == OP_MTLO) begin
              lo_reg <= a;
            end else if (is_arith(op)) begin
              cnt_reg <= '0;
              div_reg <= is_div(op);
              if (div_zero) begin
                // FIX passes these straight through: HI=a, LO=all-ones.
                acc_reg <= a;
                q_reg   <= '1;
              end else if (is_div(op)) begin
                acc_reg  <= '0;
                q_reg    <= a_mag;
                opnd_reg <= b_mag;
              end else begin
                acc_reg  <= '0;
                q_reg    <= b_mag;
                opnd_reg <= a_mag;
              end
            end
          end
        end
        ST_ITER: begin
          acc_reg <= acc_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
        ST_FIX: begin
          hi_reg <= fix_hi;
          lo_reg <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
